// File: rtl/error_diffusion_writer.sv
// Floyd-Steinberg error distribution: read-modify-writes the four forward neighbours
// of a quantised pixel in a single-port synchronous image RAM.
module error_diffusion_writer #(
   parameter int IMAGEX           = 64,
   parameter int IMAGEY           = 64,
   parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGEX*IMAGEY),
   parameter int RGB_SIZE         = 8,
   parameter int ERR_WIDTH        = RGB_SIZE+1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [IMAGE_ADDR_WIDTH-1:0] in_addr,
   input  logic [ERR_WIDTH-1:0]        in_err,
   output logic                        mem_rd_en,
   output logic                        mem_wr_en,
   output logic [IMAGE_ADDR_WIDTH-1:0] mem_addr,
   input  logic [RGB_SIZE-1:0]         mem_rd_data,
   output logic [RGB_SIZE-1:0]         mem_wr_data,
   output logic                        busy,
   output logic                        done
);

   localparam int AW    = IMAGE_ADDR_WIDTH;
   localparam int XW    = $clog2(IMAGEX);
   localparam int YW    = AW - XW;
   localparam int SUM_W = RGB_SIZE + 6;

   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

   state_t                state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [ERR_WIDTH-1:0]  err_q, err_d;
   logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
   logic [AW-1:0]         maddr_q, maddr_d;
   logic [RGB_SIZE-1:0]   wdata_q, wdata_d;
   logic                  done_q, done_d, busy_q, busy_d, ready_q, ready_d;

   logic [AW-1:0]         src_addr_s;
   logic [3:0]            mask_s;
   logic [2:0]            next_s;
   logic signed [SUM_W-1:0] prod_s, delta_s, sum_s;
   logic [RGB_SIZE-1:0]   result_s;

   // Bit order E, SW, S, SE: which neighbours lie inside the image.
   function automatic logic [3:0] nb_mask(input logic [AW-1:0] a);
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic          xl, xr, yb;
      x  = a[XW-1:0];
      y  = a[AW-1:XW];
      xl = (x == {XW{1'b0}});
      xr = (x == {XW{1'b1}});
      yb = (y == {YW{1'b1}});
      return {!xr && !yb, !yb, !xl && !yb, !xr};
   endfunction

   // Returns {found, index} of the lowest in-bounds neighbour at or after start.
   function automatic logic [2:0] first_nb(input logic [3:0] mask, input logic [2:0] start);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i] && (i >= int'(start))) begin
            r = {1'b1, 2'(i)};
         end
      end
      return r;
   endfunction

   function automatic logic [AW-1:0] nb_addr(input logic [AW-1:0] a, input logic [1:0] k);
      case (k)
         2'd0:    return a + AW'(1);
         2'd1:    return a + AW'(IMAGEX - 1);
         2'd2:    return a + AW'(IMAGEX);
         default: return a + AW'(IMAGEX + 1);
      endcase
   endfunction

   function automatic logic [3:0] nb_weight(input logic [1:0] k);
      case (k)
         2'd0:    return 4'd7;
         2'd1:    return 4'd3;
         2'd2:    return 4'd5;
         default: return 4'd1;
      endcase
   endfunction

   // Weighted share with floor shift, then clamp of old pixel plus share.
   always_comb begin
      prod_s  = $signed({{(SUM_W-ERR_WIDTH){err_q[ERR_WIDTH-1]}}, err_q})
              * $signed({{(SUM_W-4){1'b0}}, nb_weight(idx_q)});
      delta_s = prod_s >>> 4;
      sum_s   = $signed({{(SUM_W-RGB_SIZE){1'b0}}, mem_rd_data}) + delta_s;
      if (sum_s[SUM_W-1]) begin
         result_s = {RGB_SIZE{1'b0}};
      end else if (|sum_s[SUM_W-2:RGB_SIZE]) begin
         result_s = {RGB_SIZE{1'b1}};
      end else begin
         result_s = sum_s[RGB_SIZE-1:0];
      end
   end

   always_comb begin
      src_addr_s = (state_q == IDLE) ? in_addr : addr_q;
      mask_s     = nb_mask(src_addr_s);
      next_s     = first_nb(mask_s, (state_q == IDLE) ? 3'd0 : ({1'b0, idx_q} + 3'd1));
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      err_d   = err_q;
      rd_en_d = 1'b0;
      wr_en_d = 1'b0;
      maddr_d = maddr_q;
      wdata_d = wdata_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      ready_d = ready_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               addr_d = in_addr;
               err_d  = in_err;
               busy_d = 1'b1;
               ready_d = 1'b0;
               if (next_s[2]) begin
                  state_d = READ;
                  idx_d   = next_s[1:0];
                  rd_en_d = 1'b1;
                  maddr_d = nb_addr(in_addr, next_s[1:0]);
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         READ: state_d = WAIT;
         WAIT: begin
            state_d = WRITE;
            wr_en_d = 1'b1;
            wdata_d = result_s;
         end
         WRITE: begin
            if (next_s[2]) begin
               state_d = READ;
               idx_d   = next_s[1:0];
               rd_en_d = 1'b1;
               maddr_d = nb_addr(addr_q, next_s[1:0]);
            end else begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   // Reset drops any write that was about to be issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         addr_q  <= '0;
         err_q   <= '0;
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
         maddr_q <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         rd_en_q <= rd_en_d;
         wr_en_q <= wr_en_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   assign in_ready    = ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign mem_rd_en   = rd_en_q;
   assign mem_wr_en   = wr_en_q;
   assign mem_addr    = maddr_q;
   assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_error_diffusion_writer.sv
// Bench for error_diffusion_writer: behavioural RAM plus a reference model of the
// neighbour update rules, directed scenarios followed by random jobs.
module tb_error_diffusion_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] in_addr = 12'd0;
   logic [8:0]  in_err = 9'd0;
   logic        mem_rd_en, mem_wr_en;
   logic [11:0] mem_addr;
   logic [7:0]  mem_rd_data = 8'd0;
   logic [7:0]  mem_wr_data;
   logic        busy, done;

   logic [7:0]  ram [0:4095];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   error_diffusion_writer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_err(in_err), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd_en) mem_rd_data <= ram[mem_addr];
      if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < 4096; i++) ram[i] = 8'(v);
   endtask

   // Offer one job, watch it to completion and compare against the reference model.
   task automatic do_job(input int a, input int e, input bit hold, input string tag,
                         output int done_at);
      int dxs[4] = '{1, -1, 0, 1};
      int dys[4] = '{0, 1, 1, 1};
      int ws[4]  = '{7, 3, 5, 1};
      int ea[$], ed[$], wa[$], wd[$];
      int x, y, nx, ny, p, d, v, n, reads, overlap, bad, acc, waitc;
      bit got;
      x = a % 64;
      y = a / 64;
      for (int k = 0; k < 4; k++) begin
         nx = x + dxs[k];
         ny = y + dys[k];
         if (nx >= 0 && nx < 64 && ny < 64) begin
            p = e * ws[k];
            d = (p >= 0) ? p / 16 : -((-p + 15) / 16);
            v = int'(ram[ny*64 + nx]) + d;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            ea.push_back(ny*64 + nx);
            ed.push_back(v);
         end
      end
      n = ea.size();
      waitc = 0;
      while (!in_ready && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      check({tag, "_ready"}, longint'(in_ready), 1);
      in_valid = 1'b1;
      in_addr  = 12'(a);
      in_err   = 9'(e);
      acc = cyc;
      got = 1'b0;
      reads = 0; overlap = 0; bad = 0; done_at = -1;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (c == 0) begin
            if (hold) in_addr = 12'(a ^ 12'h005);
            else in_valid = 1'b0;
         end
         if (mem_wr_en) begin
            wa.push_back(int'(mem_addr));
            wd.push_back(int'(mem_wr_data));
         end
         if (mem_rd_en) reads++;
         if (mem_rd_en && mem_wr_en) overlap++;
         if (in_ready || !busy) bad++;
         if (done) begin
            got = 1'b1;
            done_at = cyc;
         end
      end
      check({tag, "_done_seen"}, longint'(got), 1);
      check({tag, "_latency"}, done_at - acc, 1 + 3*n);
      check({tag, "_nwrites"}, wa.size(), n);
      check({tag, "_nreads"}, reads, n);
      check({tag, "_rdwr_overlap"}, overlap, 0);
      check({tag, "_busy_ready"}, bad, 0);
      for (int i = 0; i < n && i < wa.size(); i++) begin
         check($sformatf("%s_waddr%0d", tag, i), wa[i], ea[i]);
         check($sformatf("%s_wdata%0d", tag, i), wd[i], ed[i]);
      end
   endtask

   initial begin
      int t, t2, wr_after;
      bit same;
      repeat (3) @(negedge clk);
      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_rd_en", longint'(mem_rd_en), 0);
      check("rst_wr_en", longint'(mem_wr_en), 0);
      check("rst_mem_addr", longint'(mem_addr), 0);
      check("rst_wr_data", longint'(mem_wr_data), 0);
      rst = 1'b0;
      @(negedge clk);

      fill(100);
      do_job(330, 32, 1'b0, "interior", t);
      check("interior_ram331", ram[331], 114);
      check("interior_ram395", ram[395], 102);
      @(negedge clk);
      fill(10);
      do_job(330, -48, 1'b0, "negclamp", t);
      @(negedge clk);
      fill(250);
      do_job(330, 255, 1'b0, "posclamp", t);
      @(negedge clk);
      fill(120);
      do_job(63, 100, 1'b0, "edge63", t);
      @(negedge clk);
      do_job(0, -100, 1'b0, "edge0", t);
      @(negedge clk);
      do_job(4095, 77, 1'b0, "edge4095", t);
      @(negedge clk);

      // Backpressure: valid held through the job, next job taken in the first idle cycle.
      fill(100);
      do_job(330, 32, 1'b1, "bp_first", t);
      do_job(330, 40, 1'b0, "bp_second", t2);
      check("bp_second_gap", t2 - t, 2 + 3*4);
      @(negedge clk);

      // Reset while waiting for the E neighbour's read data.
      fill(100);
      in_valid = 1'b1; in_addr = 12'd330; in_err = 9'd32;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstmid_busy", longint'(busy), 0);
      check("rstmid_in_ready", longint'(in_ready), 1);
      check("rstmid_rd_en", longint'(mem_rd_en), 0);
      wr_after = int'(mem_wr_en);
      repeat (4) begin
         @(negedge clk);
         wr_after += int'(mem_wr_en);
      end
      check("rstmid_no_write", wr_after, 0);
      same = (ram[331] == 8'd100) && (ram[393] == 8'd100) && (ram[394] == 8'd100)
             && (ram[395] == 8'd100);
      check("rstmid_ram_unchanged", longint'(same), 1);
      do_job(330, 32, 1'b0, "after_rst", t);
      @(negedge clk);

      for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom_range(0, 255));
      for (int j = 0; j < 25; j++) begin
         int a, e, r;
         r = int'($urandom_range(0, 7));
         case (r)
            0:       a = 0;
            1:       a = 4095;
            2:       a = 63;
            3:       a = 4032;
            default: a = int'($urandom_range(0, 4095));
         endcase
         e = int'($urandom_range(0, 511)) - 256;
         do_job(a, e, 1'b0, $sformatf("rand%0d", j), t);
         repeat (int'($urandom_range(1, 3))) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
